rr_arbiter_4: RTL
=================

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive cycles one grant may be held; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req  input  4  request lines; req[i]=1 means requester i wants the resource.
REQ-005 done  input  1  current owner releases the grant; sampled only in GRANT.
REQ-006 grant_idx  output  2  registered binary index of the current or last owner; drives the downstream 2:4 decoder select.
REQ-007 grant_en  output  1  registered grant-valid; drives the downstream 2:4 decoder enable.
REQ-008 timeout  output  1  registered one-cycle pulse on a forced release at MAX_HOLD.

Function
REQ-009 The block SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-010 The block SHALL keep an internal 2-bit priority pointer ptr and an 8-bit hold counter cnt.
REQ-011 IDLE with req==0: SHALL stay in IDLE with grant_en=0 and grant_idx unchanged.
REQ-012 IDLE with req!=0: SHALL pick the winner as the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-013 On that IDLE edge the block SHALL register grant_idx=winner, grant_en=1, cnt=1, and move to GRANT.
REQ-014 Latency SHALL be one cycle: req is sampled at edge N and grant_en is high after edge N.
REQ-015 GRANT SHALL hold grant_idx stable and increment cnt each cycle until a release condition holds.
REQ-016 Release conditions, evaluated on each GRANT edge:
  - (a) done=1
  - (b) req[grant_idx]=0
  - (c) cnt==MAX_HOLD
REQ-017 On release the block SHALL:
  - set grant_en=0
  - set ptr=grant_idx+1 (mod 4, 3 wraps to 0)
  - clear cnt to 0
  - move to IDLE
  - leave grant_idx holding the last owner
REQ-018 timeout SHALL pulse high for exactly the cycle following a release caused only by (c); if (a) or (b) holds on the same edge, timeout SHALL stay 0.
REQ-019 Every grant SHALL be followed by at least one IDLE cycle with grant_en=0, so back-to-back owners are separated by one low cycle on grant_en.
REQ-020 With MAX_HOLD=1, every grant SHALL last exactly one cycle and timeout SHALL pulse if neither done nor request drop coincides.
REQ-021 New requests arriving during GRANT SHALL NOT preempt the owner; they are arbitrated at the next IDLE edge.
REQ-022 done asserted in IDLE SHALL be ignored.
REQ-023 Arbitration SHALL be starvation-free: any continuously held request is granted within 4 grant/idle rounds.
REQ-024 grant_idx SHALL never change while grant_en=1.

Reset
REQ-025 While rst=1 the block SHALL immediately force state=IDLE, grant_en=0, grant_idx=2'b00, timeout=0, ptr=0, cnt=0, regardless of clk.
REQ-026 rst asserted mid-GRANT SHALL drop grant_en asynchronously, and the priority pointer SHALL restart at 0.
REQ-027 After rst deasserts, the first arbitration SHALL occur on the first rising edge at which rst is low.

Verification
REQ-028 Reset then req=4'b0101 held: grant_en=1 and grant_idx=0 one cycle later; done pulse gives grant_en=0 for one cycle, then grant_idx=2 with grant_en=1.
REQ-029 req=4'b1111 held, done pulsed every grant: grant_idx sequence is 0,1,2,3,0, each grant separated by one grant_en=0 cycle.
REQ-030 MAX_HOLD=8, req=4'b0010 held, done=0: grant_en high exactly 8 cycles, then grant_en=0 with timeout=1 for one cycle, then regrant of idx 1 the next cycle.
REQ-031 Owner idx 3 drops req[3] mid-grant while req=4'b0001 remains: release the next edge with timeout=0, then grant_idx=0 (pointer wrap 3->0).
REQ-032 rst pulsed asynchronously mid-grant of idx 2 with req=4'b0110: grant_en=0 immediately; after release, idx 1 is granted first (ptr=0).
REQ-033 done and cnt==MAX_HOLD on the same edge: release with timeout=0; req=0 in IDLE keeps grant_en=0 indefinitely.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-way round-robin arbiter with a bounded hold time.
// One owner at a time. Each grant ends on done, on the owner dropping its
// request, or after MAX_HOLD cycles. Every grant is followed by at least
// one idle cycle. grant_idx keeps the last owner after the grant ends, so
// the downstream 2:4 decoder select only moves when a new grant starts.
//
// state | meaning
// IDLE  | no owner; next edge arbitrates among req from ptr upward
// GRANT | grant_idx owns the resource; cnt counts cycles held
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] grant_idx,
    output logic       grant_en,
    output logic       timeout
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] grant_idx_q, grant_idx_d;
    logic       grant_en_q, grant_en_d;
    logic       timeout_q, timeout_d;

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;

    logic       rel_done;
    logic       rel_drop;
    logic       rel_max;
    logic       release_now;

    // Rotating priority scan: pick the first requester at ptr, ptr+1, ...
    // Scanning from the far end lets the nearest hit overwrite later ones.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Release conditions for the current owner; only meaningful in GRANT.
    always_comb begin
        rel_done    = done;
        rel_drop    = ~req[grant_idx_q];
        rel_max     = (cnt_q == HOLD_LIMIT);
        release_now = rel_done | rel_drop | rel_max;
    end

    // Next-state and next-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        grant_idx_d = grant_idx_q;
        grant_en_d  = grant_en_q;
        timeout_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                grant_en_d = 1'b0;
                if (win_found) begin
                    grant_idx_d = win_idx;
                    grant_en_d  = 1'b1;
                    cnt_d       = 8'd1;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    grant_en_d = 1'b0;
                    ptr_d      = grant_idx_q + 2'd1;
                    cnt_d      = 8'd0;
                    state_d    = ST_IDLE;
                    // Timeout is flagged only when the hold limit alone ended the grant.
                    timeout_d  = rel_max & ~rel_done & ~rel_drop;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_en_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            cnt_q       <= 8'd0;
            grant_idx_q <= 2'd0;
            grant_en_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            grant_idx_q <= grant_idx_d;
            grant_en_q  <= grant_en_d;
            timeout_q   <= timeout_d;
        end
    end

    assign grant_idx = grant_idx_q;
    assign grant_en  = grant_en_q;
    assign timeout   = timeout_q;

endmodule
